// File: rtl/pc_seq_if.sv
// Bundle between the controller/comparator side and the program-counter
// sequencer: redirect requests in, fetch address and status out.
interface pc_seq_if;
   logic        stall;
   logic        br_valid;
   logic        br_taken;
   logic [15:0] br_imm;
   logic        j_valid;
   logic [25:0] j_index;
   logic        jr_valid;
   logic [31:0] jr_addr;
   logic        halt_req;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic        pend_valid;
   logic        halted;
   logic        addr_err;

   modport master (
      output stall, br_valid, br_taken, br_imm, j_valid, j_index,
             jr_valid, jr_addr, halt_req,
      input  pc, pc4, pend_valid, halted, addr_err
   );

   modport slave (
      input  stall, br_valid, br_taken, br_imm, j_valid, j_index,
             jr_valid, jr_addr, halt_req,
      output pc, pc4, pend_valid, halted, addr_err
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer: picks PC+4 / branch / jump / register target,
// buffers a redirect seen during a stall, and halts on request or on a bad
// fetch address.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter int          IMEM_WORDS = 1024
) (
   input logic     clk,
   input logic     reset,
   pc_seq_if.slave bus
);

   localparam logic [31:0] LAST_PC = RESET_PC + 32'(4 * IMEM_WORDS) - 32'd4;

   typedef enum logic [1:0] {RUN, HOLD, HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_q, pend_d;
   logic        pend_v_q, pend_v_d;
   logic        err_q, err_d;

   logic [31:0] pc4;
   logic [31:0] br_tgt;
   logic [31:0] j_tgt;
   logic [31:0] sel_tgt;
   logic [31:0] seq_load;
   logic        redirect;

   // Fault when the address is misaligned or falls outside instruction memory.
   function automatic logic addr_bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a < RESET_PC) || (a > LAST_PC);
   endfunction

   assign pc4    = pc_q + 32'd4;
   assign br_tgt = pc4 + {{14{bus.br_imm[15]}}, bus.br_imm, 2'b00};
   assign j_tgt  = {pc4[31:28], bus.j_index, 2'b00};

   // Redirect selection: register jump beats direct jump beats taken branch.
   always_comb begin
      redirect = bus.jr_valid | bus.j_valid | (bus.br_valid & bus.br_taken);
      sel_tgt  = br_tgt;
      if (bus.jr_valid)
         sel_tgt = bus.jr_addr;
      else if (bus.j_valid)
         sel_tgt = j_tgt;
      seq_load = redirect ? sel_tgt : pc4;
   end

   // Next-state logic; targets are range-checked only when they load into pc.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      err_d    = err_q;
      unique case (state_q)
         RUN: begin
            if (bus.halt_req) begin
               state_d = HALT;
            end else if (bus.stall) begin
               if (redirect) begin
                  pend_d   = sel_tgt;
                  pend_v_d = 1'b1;
                  state_d  = HOLD;
               end
            end else if (addr_bad(seq_load)) begin
               err_d   = 1'b1;
               state_d = HALT;
            end else begin
               pc_d = seq_load;
            end
         end
         HOLD: begin
            if (bus.halt_req) begin
               pend_d   = '0;
               pend_v_d = 1'b0;
               state_d  = HALT;
            end else if (!bus.stall) begin
               pend_v_d = 1'b0;
               if (addr_bad(pend_q)) begin
                  err_d   = 1'b1;
                  state_d = HALT;
               end else begin
                  pc_d    = pend_q;
                  state_d = RUN;
               end
            end
         end
         default: begin
            state_d = HALT;
         end
      endcase
   end

   // State and PC registers; reset dominates every other input.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= RUN;
         pc_q     <= RESET_PC;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         err_q    <= err_d;
      end
   end

   assign bus.pc         = pc_q;
   assign bus.pc4        = pc4;
   assign bus.pend_valid = pend_v_q;
   assign bus.halted     = (state_q == HALT);
   assign bus.addr_err   = err_q;

endmodule
